// File: rtl/cb_seg_core.sv
// cb_seg_core: transport-block to code-block segmentation with filler insertion and per-block CRC24B.
// Ports:
//   clk, reset (async active-low)
//   tb_in/wreq_data      serial transport-block bit and its strobe
//   tb_size_in/wreq_size block length B (bits, TB CRC included) and its strobe
//   cb_data, filling, crc, start, stop, cb_size: registered serial code-block stream and markers
`timescale 1ns/1ps
module cb_seg_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        tb_in,
  input  logic        wreq_data,
  input  logic [15:0] tb_size_in,
  input  logic        wreq_size,
  output logic        filling,
  output logic        crc,
  output logic        start,
  output logic        stop,
  output logic        cb_size,
  output logic        cb_data
);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
  state_t state, state_nx;
  logic mem [0:12239];
  logic [13:0] idx;
  logic [1:0] c, c_w;
  logic [15:0] b, kp, km, cm, f, pos, blk;
  logic [15:0] bp_w, t_w, kp_w, km_w, cm_w, f_w, cur_k;
  logic [2:0] sh_w;
  logic [23:0] crc_r, crc_nx;
  logic is_fill, is_crc, last, done, bit_v, fb;
  // B<=12240 means C is at most 2, so the per-block target is B' or ceil(B'/2);
  // K+ rounds that target up to the step of its table region, and every dK is a power of two.
  always_comb begin
    c_w = (b > 16'd6144) ? 2'd2 : 2'd1;
    bp_w = (c_w == 2'd2) ? b + 16'd48 : b;
    t_w = (c_w == 2'd2) ? (bp_w + 16'd1) >> 1 : bp_w;
    kp_w = (t_w <= 16'd40)   ? 16'd40 :
           (t_w <= 16'd512)  ? (t_w + 16'd7)  & 16'hFFF8 :
           (t_w <= 16'd1024) ? (t_w + 16'd15) & 16'hFFF0 :
           (t_w <= 16'd2048) ? (t_w + 16'd31) & 16'hFFE0 : (t_w + 16'd63) & 16'hFFC0;
    sh_w = (kp_w <= 16'd512) ? 3'd3 : (kp_w <= 16'd1024) ? 3'd4 : (kp_w <= 16'd2048) ? 3'd5 : 3'd6;
    km_w = (c_w == 2'd2) ? kp_w - (16'd1 << sh_w) : 16'd0;
    cm_w = (c_w == 2'd2) ? ({kp_w[14:0], 1'b0} - bp_w) >> sh_w : 16'd0;
    f_w = ((c_w == 2'd2) ? {kp_w[14:0], 1'b0} - (cm_w << sh_w) : kp_w) - bp_w;
  end
  always_comb begin
    cur_k = (blk < cm) ? km : kp;
    last = pos == cur_k - 16'd1;
    done = last && blk == {14'd0, c} - 16'd1;
    is_fill = blk == 16'd0 && pos < f;
    is_crc = c == 2'd2 && pos >= cur_k - 16'd24;
    bit_v = is_fill ? 1'b0 : is_crc ? crc_r[23] : mem[idx];
    fb = bit_v ^ crc_r[23];
    // CRC bits shift out MSB first; after 24 shifts the register is clear for the next block
    crc_nx = is_crc ? {crc_r[22:0], 1'b0} : {crc_r[22:0], 1'b0} ^ (fb ? 24'h800063 : 24'h0);
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && wreq_size && tb_size_in != 16'd0 && tb_size_in <= 16'd12240) state_nx = LOAD;
    if (state == LOAD && wreq_data && {2'd0, idx} == b - 16'd1) state_nx = CALC;
    if (state == CALC) state_nx = OUT;
    if (state == OUT && done) state_nx = IDLE;
  end
  always_ff @(posedge clk)
    if (state == LOAD && wreq_data) mem[idx] <= tb_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      {idx, c, b, kp, km, cm, f, pos, blk, crc_r} <= '0;
      {filling, crc, start, stop, cb_size, cb_data} <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == LOAD) begin
        b <= tb_size_in;
        idx <= 14'd0;
      end
      if (state == LOAD && wreq_data) idx <= idx + 14'd1;
      if (state == CALC) begin
        {c, kp, km, cm, f} <= {c_w, kp_w, km_w, cm_w, f_w};
        {idx, pos, blk, crc_r} <= '0;
      end
      if (state == OUT) begin
        idx <= (!is_fill && !is_crc) ? idx + 14'd1 : idx;
        pos <= last ? 16'd0 : pos + 16'd1;
        blk <= last ? blk + 16'd1 : blk;
        crc_r <= crc_nx;
      end
      cb_data <= state == OUT && bit_v;
      filling <= state == OUT && is_fill;
      crc <= state == OUT && is_crc;
      start <= state == OUT && pos == 16'd0;
      stop <= state == OUT && last;
      cb_size <= state == OUT && blk >= cm;
    end
endmodule

// File: tb/tb_cb_seg_core.sv
// tb_cb_seg_core: randomized self-checking bench for cb_seg_core against a table-search segmentation model.
`timescale 1ns/1ps
module tb_cb_seg_core;
  logic clk = 1'b0, reset = 1'b0, tb_in = 1'b0, wreq_data = 1'b0, wreq_size = 1'b0;
  logic [15:0] tb_size_in = 16'd0;
  logic filling, crc, start, stop, cb_size, cb_data;
  logic [5:0] outs, idle_v;
  logic [24:0] g_poly = 25'h1800063;
  bit data_q[$];
  logic [5:0] exp_q[$], got_q[$];
  int n_chk = 0, n_fail = 0, exp_f;
  assign outs = {cb_data, filling, crc, start, stop, cb_size};
  cb_seg_core dut (
    .clk(clk), .reset(reset), .tb_in(tb_in), .wreq_data(wreq_data), .tb_size_in(tb_size_in),
    .wreq_size(wreq_size), .filling(filling), .crc(crc), .start(start), .stop(stop),
    .cb_size(cb_size), .cb_data(cb_data)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // remainder of msg(D)*D^24 divided by gCRC24B, by long division
  function automatic logic [23:0] crc24(input bit msg[$]);
    bit r[$];
    r = msg;
    repeat (24) r.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (r[i]) for (int j = 0; j < 25; j++) r[i + j] = r[i + j] ^ g_poly[24 - j];
    crc24 = '0;
    for (int j = 0; j < 24; j++) crc24[23 - j] = r[msg.size() + j];
  endfunction
  task automatic model(input int b);
    int ks[$];
    int c, bp, kp, km, cm, f, pos;
    bit msg[$];
    logic [23:0] r;
    for (int k = 40; k <= 6144; k += (k < 512) ? 8 : (k < 1024) ? 16 : (k < 2048) ? 32 : 64) ks.push_back(k);
    c = (b <= 6144) ? 1 : (b + 6119) / 6120;
    bp = (b <= 6144) ? b : b + 24 * c;
    kp = 0;
    km = 0;
    foreach (ks[i]) if (kp == 0 && c * ks[i] >= bp) begin kp = ks[i]; km = (i > 0) ? ks[i - 1] : 0; end
    if (c == 1) km = 0;
    cm = (c == 1) ? 0 : (c * kp - bp) / (kp - km);
    f = (c - cm) * kp + cm * km - bp;
    exp_f = f;
    exp_q.delete();
    pos = 0;
    for (int blk = 0; blk < c; blk++) begin
      int k = (blk < cm) ? km : kp;
      msg.delete();
      for (int i = 0; i < k - ((c > 1) ? 24 : 0); i++) begin
        bit fill = blk == 0 && i < f;
        bit d = fill ? 1'b0 : data_q[pos];
        if (!fill) pos++;
        msg.push_back(d);
        exp_q.push_back({d, fill, 1'b0, i == 0, i == k - 1, blk >= cm});
      end
      if (c > 1) begin
        r = crc24(msg);
        for (int j = 0; j < 24; j++) exp_q.push_back({r[23 - j], 1'b0, 1'b1, 1'b0, j == 23, blk >= cm});
      end
    end
  endtask
  task automatic send(input int b, input bit gaps, input bit junk);
    wreq_size = 1'b1;
    tb_size_in = 16'(b);
    tick();
    wreq_size = 1'b0;
    for (int i = 0; i < data_q.size(); i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        wreq_data = 1'b0;
        tb_in = 1'($urandom);
        tick();
      end
      wreq_size = junk && i == 1;
      tb_size_in = 16'($urandom_range(1, 60));
      wreq_data = 1'b1;
      tb_in = data_q[i];
      tick();
      wreq_size = 1'b0;
    end
    wreq_data = 1'b0;
    tb_in = 1'b0;
  endtask
  task automatic capture(input int n, output int lat);
    lat = 0;
    got_q.delete();
    while (!start && lat < 300) begin tick(); lat++; end
    if (start) for (int i = 0; i < n; i++) begin got_q.push_back(outs); tick(); end
    idle_v = outs;
  endtask
  function automatic int first_diff(input int n);
    for (int i = 0; i < n; i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction
  task automatic test_reset();
    repeat (3) tick();
    n_chk++;
    if (outs !== 6'b0) begin n_fail++; $display("FAIL reset_hold outs got %b want 000000", outs); end
    reset = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (outs !== 6'b0) begin n_fail++; $display("FAIL reset_release outs got %b want 000000", outs); end
  endtask
  task automatic test_transfer(input string name, input int b, input bit zeros, input bit gaps, input bit junk);
    int lat, d, nf;
    logic [5:0] gv;
    data_q.delete();
    for (int i = 0; i < b; i++) data_q.push_back(zeros ? 1'b0 : 1'($urandom));
    model(b);
    send(b, gaps, junk);
    capture(exp_q.size(), lat);
    n_chk++;
    if (lat > 256) begin n_fail++; $display("FAIL %s latency got %0d want <=256", name, lat); end
    d = first_diff(exp_q.size());
    n_chk++;
    if (d != -1) begin
      gv = (d < got_q.size()) ? got_q[d] : 6'bx;
      n_fail++;
      $display("FAIL %s stream (B=%0d) bit %0d got %b want %b", name, b, d, gv, exp_q[d]);
    end
    nf = 0;
    foreach (got_q[i]) nf += int'(got_q[i][4]);
    n_chk++;
    if (nf != exp_f) begin n_fail++; $display("FAIL %s filler_count got %0d want %0d", name, nf, exp_f); end
    n_chk++;
    if (idle_v !== 6'b0) begin n_fail++; $display("FAIL %s idle_after got %b want 000000", name, idle_v); end
  endtask
  task automatic test_reset_mid_out();
    int lat, d;
    data_q.delete();
    for (int i = 0; i < 6145; i++) data_q.push_back(1'($urandom));
    model(6145);
    send(6145, 1'b0, 1'b0);
    capture(3500, lat);
    d = first_diff(3500);
    n_chk++;
    if (d != -1) begin n_fail++; $display("FAIL mid_reset prefix bit %0d differs (got %0d bits)", d, got_q.size()); end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (outs !== 6'b0) begin n_fail++; $display("FAIL mid_reset immediate outs got %b want 000000", outs); end
    repeat (3) tick();
    n_chk++;
    if (outs !== 6'b0) begin n_fail++; $display("FAIL mid_reset held outs got %b want 000000", outs); end
    reset = 1'b1;
    tick();
  endtask
  task automatic test_invalid();
    int bad = 0;
    wreq_size = 1'b1;
    tb_size_in = 16'd0;
    tick();
    tb_size_in = 16'd12241;
    tick();
    wreq_size = 1'b0;
    repeat (60) begin
      wreq_data = 1'b1;
      tb_in = 1'b1;
      tick();
      if (outs !== 6'b0) bad++;
    end
    wreq_data = 1'b0;
    tb_in = 1'b0;
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL invalid_size active_cycles got %0d want 0", bad); end
  endtask
  initial begin
    test_reset();
    test_transfer("b40", 40, 1'b0, 1'b0, 1'b0);
    test_transfer("b100", 100, 1'b0, 1'b1, 1'b0);
    test_transfer("b6145", 6145, 1'b0, 1'b0, 1'b0);
    test_transfer("b12240_zero", 12240, 1'b1, 1'b0, 1'b0);
    test_reset_mid_out();
    test_transfer("b40_after_reset", 40, 1'b0, 1'b0, 1'b0);
    test_invalid();
    test_transfer("b40_after_invalid", 40, 1'b0, 1'b0, 1'b0);
    repeat (3) test_transfer("rand_small", $urandom_range(1, 700), 1'b0, 1'b1, 1'b1);
    test_transfer("rand_large", $urandom_range(6145, 8000), 1'b0, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
